// File: rtl/instr_loader.sv
// Encodes decoded instruction fields into RV32 words and writes them to instruction memory at consecutive addresses.
// One write strobe per accepted bundle, the cycle after acceptance; in_ready drops during the write so one bundle is in flight.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_err_code;
  logic              r_last;

  logic [31:0]       w_word;
  logic [1:0]        w_code;
  logic              w_accept;
  logic              w_restart;
  logic              w_addr_top;

  // Encoder: w_code is 0 for a legal bundle, otherwise the error code it raises.
  always_comb begin
    w_word = '0;
    w_code = 2'd0;
    case (in_class)
      3'd0: begin
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'd3};
        if (in_imm[12] != in_imm[11]) w_code = 2'd2;
      end
      3'd1: begin
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'd35};
        if (in_imm[12] != in_imm[11]) w_code = 2'd2;
      end
      3'd2: begin
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], 7'd99};
        if (in_imm[0]) w_code = 2'd2;
      end
      3'd3: begin
        w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'd51};
      end
      3'd4: begin
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'd127};
        if (in_imm[12] != in_imm[11]) w_code = 2'd2;
      end
      default: w_code = 2'd1;
    endcase
  end

  assign w_accept   = (r_state == ACCEPT) && in_valid;
  assign w_restart  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_addr_top = (r_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: if (start) w_next = ACCEPT;
      ACCEPT:            if (in_valid) w_next = (w_code == 2'd0) ? WRITE : ERROR;
      WRITE: begin
        if (r_last)          w_next = DONE;
        else if (w_addr_top) w_next = ERROR;
        else                 w_next = ACCEPT;
      end
      default:           w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= BASE;
      r_wdata    <= '0;
      r_count    <= '0;
      r_err_code <= 2'd0;
      r_last     <= 1'b0;
    end else if (w_restart) begin
      r_addr     <= BASE;
      r_count    <= '0;
      r_err_code <= 2'd0;
    end else if (w_accept) begin
      if (w_code == 2'd0) begin
        r_wdata <= w_word;
        r_last  <= in_last;
      end else begin
        r_err_code <= w_code;
      end
    end else if (r_state == WRITE) begin
      r_addr  <= r_addr + 1'b1;
      r_count <= r_count + 1'b1;
      if (!r_last && w_addr_top) r_err_code <= 2'd3;
    end
  end

  assign in_ready   = (r_state == ACCEPT);
  assign imem_we    = (r_state == WRITE);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_hold  = (r_state != DONE);
  assign done       = (r_state == DONE);
  assign error      = (r_state == ERROR);
  assign err_code   = r_err_code;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a 2-bit address space so the overflow path is reachable.
module tb_instr_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [2:0]    in_class = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [12:0]   in_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold, done, error;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_pass   = 0;

  instr_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error),
    .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one bundle and returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] imm, input logic last, output bit ok);
    int n;
    in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0)   $display("FAIL reset_in_ready got %b want 0", in_ready);   else n_pass++;
    n_checks++; if (imem_we !== 1'b0)    $display("FAIL reset_we got %b want 0", imem_we);          else n_pass++;
    n_checks++; if (imem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", imem_wdata);  else n_pass++;
    n_checks++; if ({done, error, err_code} !== 4'b0) $display("FAIL reset_status got %b want 0000", {done, error, err_code}); else n_pass++;
    n_checks++; if (count !== 3'd0)      $display("FAIL reset_count got %0d want 0", count);        else n_pass++;
    n_checks++; if (imem_addr !== 2'd0)  $display("FAIL reset_addr got %0d want 0", imem_addr);     else n_pass++;
    n_checks++; if (core_hold !== 1'b1)  $display("FAIL reset_hold got %b want 1", core_hold);      else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b0)   $display("FAIL idle_no_start_ready got %b want 0", in_ready); else n_pass++;
  endtask

  task automatic test_encode();
    bit ok;
    logic [31:0] exp_w [4] = '{32'h00812283, 32'h00612623, 32'hFE208CE3, 32'h402081B3};
    do_start();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL start_ready got %b want 1", in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: send(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0,    13'd8,     1'b0, ok);
        1: send(3'd1, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0,    13'd12,    1'b0, ok);
        2: send(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,    13'h1FF8,  1'b0, ok);
        default: send(3'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 13'd0, 1'b1, ok);
      endcase
      n_checks++; if (!ok) $display("FAIL enc%0d_handshake got timeout want accept", i); else n_pass++;
      n_checks++; if (imem_we !== 1'b1 || in_ready !== 1'b0) $display("FAIL enc%0d_we got we=%b rdy=%b want we=1 rdy=0", i, imem_we, in_ready); else n_pass++;
      n_checks++; if (imem_addr !== 2'(i)) $display("FAIL enc%0d_addr got %0d want %0d", i, imem_addr, i); else n_pass++;
      n_checks++; if (imem_wdata !== exp_w[i]) $display("FAIL enc%0d_word got %h want %h", i, imem_wdata, exp_w[i]); else n_pass++;
      n_checks++; if (core_hold !== 1'b1) $display("FAIL enc%0d_hold got %b want 1", i, core_hold); else n_pass++;
      tick();
      n_checks++; if (count !== 3'(i + 1)) $display("FAIL enc%0d_count got %0d want %0d", i, count, i + 1); else n_pass++;
    end
    n_checks++; if (done !== 1'b1 || core_hold !== 1'b0) $display("FAIL last_done got done=%b hold=%b want done=1 hold=0", done, core_hold); else n_pass++;
    n_checks++; if (imem_we !== 1'b0 || error !== 1'b0) $display("FAIL last_quiet got we=%b err=%b want 0 0", imem_we, error); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL done_holds got %b want 1", done); else n_pass++;
  endtask

  task automatic test_errors();
    bit ok;
    logic [1:0]  exp_code [3] = '{2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 3; i++) begin
      do_start();
      n_checks++; if (count !== 3'd0 || err_code !== 2'd0) $display("FAIL err%0d_clear got cnt=%0d code=%0d want 0 0", i, count, err_code); else n_pass++;
      case (i)
        0: send(3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0,     1'b0, ok);
        1: send(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'h0800,  1'b0, ok);
        default: send(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3, 1'b0, ok);
      endcase
      n_checks++; if (!ok) $display("FAIL err%0d_handshake got timeout want accept", i); else n_pass++;
      n_checks++; if (error !== 1'b1 || err_code !== exp_code[i]) $display("FAIL err%0d_code got err=%b code=%0d want 1 %0d", i, error, err_code, exp_code[i]); else n_pass++;
      n_checks++; if (imem_we !== 1'b0 || core_hold !== 1'b1) $display("FAIL err%0d_nowrite got we=%b hold=%b want 0 1", i, imem_we, core_hold); else n_pass++;
      tick();
      n_checks++; if (error !== 1'b1 || count !== 3'd0 || imem_we !== 1'b0) $display("FAIL err%0d_frozen got err=%b cnt=%0d we=%b want 1 0 0", i, error, count, imem_we); else n_pass++;
    end
    // LED with imm=-1 exercises sign-extended immediate and restart at base address
    do_start();
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h1FFF, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL led_handshake got timeout want accept"); else n_pass++;
    n_checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd0) $display("FAIL led_restart got we=%b addr=%0d want 1 0", imem_we, imem_addr); else n_pass++;
    n_checks++; if (imem_wdata !== 32'hFFF000FF) $display("FAIL led_word got %h want fff000ff", imem_wdata); else n_pass++;
  endtask

  task automatic test_overflow();
    bit ok;
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 13'(i), 1'b0, ok);
      n_checks++; if (!ok || imem_we !== 1'b1 || imem_addr !== 2'(i)) $display("FAIL ovf%0d_write got ok=%b we=%b addr=%0d want 1 1 %0d", i, ok, imem_we, imem_addr, i); else n_pass++;
      tick();
    end
    n_checks++; if (error !== 1'b1 || err_code !== 2'd3) $display("FAIL ovf_code got err=%b code=%0d want 1 3", error, err_code); else n_pass++;
    n_checks++; if (count !== 3'd4) $display("FAIL ovf_count got %0d want 4", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0 || core_hold !== 1'b1) $display("FAIL ovf_hold got rdy=%b hold=%b want 0 1", in_ready, core_hold); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    do_start();
    send(3'd3, 5'd7, 5'd6, 5'd5, 3'd1, 7'd1, 13'd0, 1'b1, ok);
    n_checks++; if (!ok || imem_we !== 1'b1) $display("FAIL rmw_inwrite got ok=%b we=%b want 1 1", ok, imem_we); else n_pass++;
    reset_n = 1'b0;
    tick();
    n_checks++; if (imem_we !== 1'b0 || in_ready !== 1'b0) $display("FAIL rmw_strobe got we=%b rdy=%b want 0 0", imem_we, in_ready); else n_pass++;
    n_checks++; if (imem_wdata !== 32'h0 || imem_addr !== 2'd0 || count !== 3'd0) $display("FAIL rmw_data got wd=%h addr=%0d cnt=%0d want 0 0 0", imem_wdata, imem_addr, count); else n_pass++;
    n_checks++; if (done !== 1'b0 || core_hold !== 1'b1 || error !== 1'b0) $display("FAIL rmw_status got done=%b hold=%b err=%b want 0 1 0", done, core_hold, error); else n_pass++;
    reset_n = 1'b1;
    tick(); tick();
    n_checks++; if (done !== 1'b0 || imem_we !== 1'b0) $display("FAIL rmw_dropped got done=%b we=%b want 0 0", done, imem_we); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_overflow();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
